custom_buff_cnt_seq: RTL

Upstream sequencer for the custom buffer-use decoder. On start, it sweeps the 5-bit schedule counter cnt from 0 to CNT_MAX and drives it to the decoder. It registers the 4-bit buff_use mask that comes back, together with the index that produced it. Each mask/index pair is handed downstream through a valid/ready handshake with a one-entry output register, so the counter advances only when the output slot can accept a new entry.

---
 rtl/custom_buff_cnt_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/custom_buff_cnt_seq.sv
// custom_buff_cnt_seq
//   Upstream sequencer for the custom buffer-use decoder. A start request
//   sweeps the schedule counter cnt through 0..CNT_MAX. The decoder returns a
//   4-bit buff_use mask for each index, combinationally from cnt. Each
//   mask/index pair is then placed in a one-entry output register and handed
//   downstream with valid/ready. The counter only advances when that slot can
//   take a new entry, so backpressure stalls the sweep without losing data.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   start        begin a sweep (sampled only in IDLE)
//   abort        synchronous abort back to IDLE, discards any pending entry
//   buff_use_in  decoder mask for the current cnt
//   out_ready    downstream accepts the presented entry
//   cnt          schedule index driven to the decoder
//   out_valid    out_en/out_idx/out_last hold a valid entry
//   out_en       registered buffer-use mask
//   out_idx      cnt value that produced out_en
//   out_last     entry is the final index CNT_MAX
//   busy         sequencer is not idle
//   done         one-cycle pulse when a sweep completes
module custom_buff_cnt_seq #(
    parameter int CNT_W     = 5,
    parameter int CNT_MAX   = 25,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       buff_use_in,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt,
    output logic             out_valid,
    output logic [3:0]       out_en,
    output logic [CNT_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CNT_MAX);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] out_idx_q;
    logic [3:0]       out_en_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic             busy_q;
    logic             done_q;

    logic at_last;
    logic accept;
    logic issue;
    logic drop;

    assign at_last = (cnt_q == LAST_IDX);
    assign accept  = out_valid_q && out_ready;
    // The slot can take a new entry when empty or when its entry leaves now.
    assign issue   = (state_q == RUN) && (!out_valid_q || out_ready);
    // Zero masks are dropped only when skipping is enabled. The final index is
    // always emitted, so downstream still sees out_last.
    assign drop    = SKIP_ZERO && (buff_use_in == 4'b0000) && !at_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_en_q    <= 4'b0000;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (drop) begin
                            // The slot is empty or drains this cycle, so it ends up empty.
                            out_valid_q <= 1'b0;
                            cnt_q       <= cnt_q + CNT_W'(1);
                        end else begin
                            out_valid_q <= 1'b1;
                            out_en_q    <= buff_use_in;
                            out_idx_q   <= cnt_q;
                            out_last_q  <= at_last;
                            if (at_last) begin
                                state_q <= DRAIN;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        out_valid_q <= 1'b0;
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cnt       = cnt_q;
    assign out_valid = out_valid_q;
    assign out_en    = out_en_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
